control_unit_decode: RTL and testbench
======================================

Name: control_unit_decode

Overview:
- Decode-stage control unit: maps a 5-bit instruction opcode to the datapath control bundle.
- Covers three data classes (integer, PF fixed/float, vector), each with ALU and memory ops, plus a control-flow group.
- Outputs are registered, so the bundle lines up with the ID/EX pipeline register.

Parameters:
- none (opcode width fixed at 5, ALUOp width fixed at 4)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-low reset (asserted when 0)
- Opcode  in  5  instruction opcode [4:0]
- ALUOp  out  4  ALU function select
- RegDst  out  1  1 = write-back dest is rd field; 0 = rt field
- ALUSrc  out  1  1 = ALU operand B is the immediate
- MemRead  out  1  data memory read
- MemWrite  out  1  data memory write
- MemtoReg  out  1  1 = write-back data from memory
- RegWrite  out  1  register file write enable
- Branch  out  1  control-flow instruction
- BranchOp  out  1  1 = conditional (BEQ); 0 = unconditional
- RegSrc1  out  1  1 = operand A read from vector register file
- RegSrc2  out  1  1 = second read address taken from rd field (store data)
- ALUDest  out  1  1 = result written to vector register file
- Vector_Op  out  1  opcode group 10
- PF_op  out  1  opcode group 01
- ImmSrc  out  1  1 = wide branch immediate; 0 = short immediate
- Integer_op  out  1  opcode group 00

Behaviour:
- Group field G = Opcode[4:3]: 00 integer, 01 PF, 10 vector, 11 control.
- For G in {00, 01, 10}, sub-op is Opcode[2:0]. ALUOp and ALUSrc, as they apply to each sub-op:
  - 000 ADD: ALUOp 0000, RegDst=1, RegWrite=1
  - 001 SUB: ALUOp 0001, RegDst=1, RegWrite=1
  - 010 MUL: ALUOp 0010, RegDst=1, RegWrite=1
  - 011 ADDI: ALUOp 0000, ALUSrc=1, RegWrite=1
  - 100 LDR: ALUOp 0000, ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1
  - 101 STR: ALUOp 0000, ALUSrc=1, MemWrite=1, RegSrc2=1
  - 110, 111: illegal, default bundle
- Class flags for legal ops in groups 00/01/10: exactly one of Integer_op, PF_op, Vector_op is set, per G.
- Vector ops additionally set RegSrc1=1, and ALUDest=1 when RegWrite=1.
- Control group G=11:
  - 11100 BEQ: Branch=1, BranchOp=1, ALUOp 0001 (compare), ImmSrc=1
  - 11101 B: Branch=1, BranchOp=0, ALUOp 0000, ImmSrc=1
  - 11000 NOP and all other 11xxx: default bundle
- Default bundle: every output 0. This is a safe bubble with no write and no memory access.
- Timing:
  - Combinational decode of Opcode, captured on the rising edge of clk.
  - Outputs reflect an opcode one cycle after it is presented.
  - No handshake; a new opcode is accepted every cycle.
- Reset:
  - When rst=0 at a rising edge, all outputs go to 0 on that edge, regardless of Opcode.
  - Reset during a stream discards the in-flight decode.
  - The first opcode after rst returns to 1 appears one cycle later.
- Outputs never carry X.
- Invariants:
  - MemRead and MemWrite are never both 1.
  - Branch=1 implies RegWrite=0.

Optional Feature:
- ILLEGAL_OP_EN defined: adds output illegal_op (1 bit, registered, reset 0). It is 1 for sub-op 110/111 in groups 00/01/10, and for 11xxx other than 11000, 11100, 11101. The rest of the bundle is still the default.
- ILLEGAL_OP_EN undefined: no illegal_op port; illegal opcodes silently give the default bundle.

Decomposition:
- Package control_unit_pkg holds:
  - localparams for the group codes, sub-op codes and full opcodes (OP_ADD=00000, OP_B=11101, ...)
  - ALUOp encodings (ALU_ADD=0000, ALU_SUB=0001, ALU_MUL=0010)
  - packed struct ctrl_t for the whole bundle, plus constant CTRL_DEFAULT (all zeros)
- One sub-module, control_decode_lut: purely combinational, Opcode -> ctrl_t. The top holds only the ctrl_t register and the reset.

Test Plan:
- rst=0 for 2 cycles with Opcode=00000 -> all outputs 0; after rst=1, ADD appears next cycle: ALUOp=0000, RegDst=1, RegWrite=1, Integer_op=1, all else 0.
- Stream 00001 SUB, 00100 LDR, one per cycle -> SUB: ALUOp=0001, RegDst=1, RegWrite=1, Integer_op=1. LDR: ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1, Integer_op=1. Each lags its opcode by one cycle.
- 01000 FADD, then 01100 FLDR -> same bundles as ADD and LDR but PF_op=1, Integer_op=0.
- 10000 VADD, then 10101 VSTR -> VADD: Vector_Op=1, RegSrc1=1, ALUDest=1, RegWrite=1, RegDst=1. VSTR: MemWrite=1, ALUSrc=1, RegSrc2=1, RegSrc1=1, ALUDest=0, RegWrite=0.
- 11101 B, then 11100 BEQ -> B: Branch=1, BranchOp=0, ImmSrc=1, RegWrite=0. BEQ: Branch=1, BranchOp=1, ALUOp=0001, ImmSrc=1.
- 11111 and 00110 -> all outputs 0 (illegal_op=1 when ILLEGAL_OP_EN is defined). Assert rst=0 mid-stream -> outputs 0 on that edge.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared decode definitions: group/sub-op/opcode codes, ALU encodings and
// the control bundle type.
package control_unit_pkg;

    localparam logic [1:0] G_INT = 2'b00;
    localparam logic [1:0] G_PF  = 2'b01;
    localparam logic [1:0] G_VEC = 2'b10;
    localparam logic [1:0] G_CTL = 2'b11;

    localparam logic [2:0] SUB_ADD  = 3'b000;
    localparam logic [2:0] SUB_SUB  = 3'b001;
    localparam logic [2:0] SUB_MUL  = 3'b010;
    localparam logic [2:0] SUB_ADDI = 3'b011;
    localparam logic [2:0] SUB_LDR  = 3'b100;
    localparam logic [2:0] SUB_STR  = 3'b101;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b00011;
    localparam logic [4:0] OP_LDR  = 5'b00100;
    localparam logic [4:0] OP_STR  = 5'b00101;
    localparam logic [4:0] OP_NOP  = 5'b11000;
    localparam logic [4:0] OP_BEQ  = 5'b11100;
    localparam logic [4:0] OP_B    = 5'b11101;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       branch;
        logic       branch_op;
        logic       reg_src1;
        logic       reg_src2;
        logic       alu_dest;
        logic       vector_op;
        logic       pf_op;
        logic       imm_src;
        logic       integer_op;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '0;

endpackage

// File: rtl/control_decode_lut.sv
// Combinational opcode -> control bundle lookup.
// ILLEGAL_OP_EN adds an illegal-opcode flag output.
module control_decode_lut
    import control_unit_pkg::*;
(
    input  logic [4:0] opcode_i,
`ifdef ILLEGAL_OP_EN
    output logic       illegal_o,
`endif
    output ctrl_t      ctrl_o
);

    logic [1:0] grp;
    logic [2:0] sub;
    logic       legal;
    logic       ill;

    assign grp = opcode_i[4:3];
    assign sub = opcode_i[2:0];

    always_comb begin
        ctrl_o = CTRL_DEFAULT;
        legal  = 1'b1;
        ill    = 1'b0;
        if (grp != G_CTL) begin
            unique case (sub)
                SUB_ADD: begin
                    ctrl_o.alu_op    = ALU_ADD;
                    ctrl_o.reg_dst   = 1'b1;
                    ctrl_o.reg_write = 1'b1;
                end
                SUB_SUB: begin
                    ctrl_o.alu_op    = ALU_SUB;
                    ctrl_o.reg_dst   = 1'b1;
                    ctrl_o.reg_write = 1'b1;
                end
                SUB_MUL: begin
                    ctrl_o.alu_op    = ALU_MUL;
                    ctrl_o.reg_dst   = 1'b1;
                    ctrl_o.reg_write = 1'b1;
                end
                SUB_ADDI: begin
                    ctrl_o.alu_src   = 1'b1;
                    ctrl_o.reg_write = 1'b1;
                end
                SUB_LDR: begin
                    ctrl_o.alu_src    = 1'b1;
                    ctrl_o.mem_read   = 1'b1;
                    ctrl_o.mem_to_reg = 1'b1;
                    ctrl_o.reg_write  = 1'b1;
                end
                SUB_STR: begin
                    ctrl_o.alu_src   = 1'b1;
                    ctrl_o.mem_write = 1'b1;
                    ctrl_o.reg_src2  = 1'b1;
                end
                default: legal = 1'b0;
            endcase
            if (legal) begin
                ctrl_o.integer_op = (grp == G_INT);
                ctrl_o.pf_op      = (grp == G_PF);
                ctrl_o.vector_op  = (grp == G_VEC);
                // Vector ops read and write the vector register file
                if (grp == G_VEC) begin
                    ctrl_o.reg_src1 = 1'b1;
                    ctrl_o.alu_dest = ctrl_o.reg_write;
                end
            end else begin
                ill = 1'b1;
            end
        end else begin
            unique case (opcode_i)
                OP_BEQ: begin
                    ctrl_o.branch    = 1'b1;
                    ctrl_o.branch_op = 1'b1;
                    ctrl_o.alu_op    = ALU_SUB;
                    ctrl_o.imm_src   = 1'b1;
                end
                OP_B: begin
                    ctrl_o.branch  = 1'b1;
                    ctrl_o.imm_src = 1'b1;
                end
                OP_NOP:  ill = 1'b0;
                default: ill = 1'b1;
            endcase
        end
    end

`ifdef ILLEGAL_OP_EN
    assign illegal_o = ill;
`else
    logic unused_ill;
    assign unused_ill = ill;
`endif

endmodule

// File: rtl/control_unit_decode.sv
// Decode-stage control unit: registers the looked-up bundle for ID/EX.
// ILLEGAL_OP_EN adds the registered illegal_op output.
module control_unit_decode
    import control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Opcode,
    output logic [3:0] ALUOp,
    output logic       RegDst,
    output logic       ALUSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       Branch,
    output logic       BranchOp,
    output logic       RegSrc1,
    output logic       RegSrc2,
    output logic       ALUDest,
    output logic       Vector_Op,
    output logic       PF_op,
    output logic       ImmSrc,
`ifdef ILLEGAL_OP_EN
    output logic       illegal_op,
`endif
    output logic       Integer_op
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

`ifdef ILLEGAL_OP_EN
    logic ill_d;
    logic ill_q;
`endif

    control_decode_lut u_lut (
        .opcode_i  (Opcode),
`ifdef ILLEGAL_OP_EN
        .illegal_o (ill_d),
`endif
        .ctrl_o    (ctrl_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q <= CTRL_DEFAULT;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

`ifdef ILLEGAL_OP_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            ill_q <= 1'b0;
        end else begin
            ill_q <= ill_d;
        end
    end
    assign illegal_op = ill_q;
`endif

    assign ALUOp      = ctrl_q.alu_op;
    assign RegDst     = ctrl_q.reg_dst;
    assign ALUSrc     = ctrl_q.alu_src;
    assign MemRead    = ctrl_q.mem_read;
    assign MemWrite   = ctrl_q.mem_write;
    assign MemtoReg   = ctrl_q.mem_to_reg;
    assign RegWrite   = ctrl_q.reg_write;
    assign Branch     = ctrl_q.branch;
    assign BranchOp   = ctrl_q.branch_op;
    assign RegSrc1    = ctrl_q.reg_src1;
    assign RegSrc2    = ctrl_q.reg_src2;
    assign ALUDest    = ctrl_q.alu_dest;
    assign Vector_Op  = ctrl_q.vector_op;
    assign PF_op      = ctrl_q.pf_op;
    assign ImmSrc     = ctrl_q.imm_src;
    assign Integer_op = ctrl_q.integer_op;

endmodule

// File: tb/tb_control_unit_decode.sv
// Directed-vector bench for control_unit_decode.
// Honours ILLEGAL_OP_EN when defined.
module tb_control_unit_decode;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] Opcode = 5'b0;
    logic [3:0] ALUOp;
    logic RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite;
    logic Branch, BranchOp, RegSrc1, RegSrc2, ALUDest;
    logic Vector_Op, PF_op, ImmSrc, Integer_op;
`ifdef ILLEGAL_OP_EN
    logic illegal_op;
`endif

    int checks = 0;
    int errors = 0;

    // Expected-bundle bit positions: {ALUOp[18:15], flags[14:0]}
    localparam logic [18:0] RD   = 19'(1) << 14;
    localparam logic [18:0] AS   = 19'(1) << 13;
    localparam logic [18:0] MR   = 19'(1) << 12;
    localparam logic [18:0] MW   = 19'(1) << 11;
    localparam logic [18:0] M2R  = 19'(1) << 10;
    localparam logic [18:0] RW   = 19'(1) << 9;
    localparam logic [18:0] BR   = 19'(1) << 8;
    localparam logic [18:0] BOP  = 19'(1) << 7;
    localparam logic [18:0] RS1  = 19'(1) << 6;
    localparam logic [18:0] RS2  = 19'(1) << 5;
    localparam logic [18:0] AD   = 19'(1) << 4;
    localparam logic [18:0] VEC  = 19'(1) << 3;
    localparam logic [18:0] PF   = 19'(1) << 2;
    localparam logic [18:0] IMM  = 19'(1) << 1;
    localparam logic [18:0] INT  = 19'(1);
    localparam logic [18:0] A_SUB = 19'(1) << 15;
    localparam logic [18:0] A_MUL = 19'(2) << 15;

    localparam logic [18:0] E_ADD  = RD | RW | INT;
    localparam logic [18:0] E_SUB  = A_SUB | RD | RW | INT;
    localparam logic [18:0] E_MUL  = A_MUL | RD | RW | INT;
    localparam logic [18:0] E_ADDI = AS | RW | INT;
    localparam logic [18:0] E_LDR  = AS | MR | M2R | RW | INT;
    localparam logic [18:0] E_STR  = AS | MW | RS2 | INT;
    localparam logic [18:0] E_FADD = RD | RW | PF;
    localparam logic [18:0] E_FLDR = AS | MR | M2R | RW | PF;
    localparam logic [18:0] E_VADD = RD | RW | VEC | RS1 | AD;
    localparam logic [18:0] E_VSTR = AS | MW | RS2 | RS1 | VEC;
    localparam logic [18:0] E_B    = BR | IMM;
    localparam logic [18:0] E_BEQ  = A_SUB | BR | BOP | IMM;

    logic [18:0] obs;
    logic [18:0] prev_exp;
    logic        prev_ill;

    assign obs = {ALUOp, RegDst, ALUSrc, MemRead, MemWrite, MemtoReg,
                  RegWrite, Branch, BranchOp, RegSrc1, RegSrc2, ALUDest,
                  Vector_Op, PF_op, ImmSrc, Integer_op};

    control_unit_decode dut (
        .clk        (clk),
        .rst        (rst),
        .Opcode     (Opcode),
        .ALUOp      (ALUOp),
        .RegDst     (RegDst),
        .ALUSrc     (ALUSrc),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .Branch     (Branch),
        .BranchOp   (BranchOp),
        .RegSrc1    (RegSrc1),
        .RegSrc2    (RegSrc2),
        .ALUDest    (ALUDest),
        .Vector_Op  (Vector_Op),
        .PF_op      (PF_op),
        .ImmSrc     (ImmSrc),
`ifdef ILLEGAL_OP_EN
        .illegal_op (illegal_op),
`endif
        .Integer_op (Integer_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [18:0] got,
                         input logic [18:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
        end
    endtask

    task automatic check_bundle(input string tag, input logic [18:0] exp,
                                input logic exp_ill);
        check(tag, obs, exp);
        check({tag, "_x"}, 19'($isunknown(obs)), 19'(0));
        check({tag, "_rdwr"}, 19'(MemRead & MemWrite), 19'(0));
        check({tag, "_brrw"}, 19'(Branch & RegWrite), 19'(0));
`ifdef ILLEGAL_OP_EN
        check({tag, "_ill"}, 19'(illegal_op), 19'(exp_ill));
`else
        if (exp_ill === 1'bx) check({tag, "_illx"}, obs, exp);
`endif
    endtask

    // Present op just after an edge, confirm the output still holds the
    // previous bundle, then confirm the new bundle after the next edge.
    task automatic step(input string tag, input logic [4:0] op,
                        input logic [18:0] exp, input logic exp_ill);
        Opcode = op;
        #1;
        check_bundle({tag, "_hold"}, prev_exp, prev_ill);
        @(posedge clk);
        #1;
        check_bundle(tag, exp, exp_ill);
        prev_exp = exp;
        prev_ill = exp_ill;
    endtask

    initial begin
        rst    = 1'b0;
        Opcode = 5'b00000;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_bundle("reset", 19'(0), 1'b0);
        prev_exp = 19'(0);
        prev_ill = 1'b0;
        rst = 1'b1;
        step("add",  5'b00000, E_ADD,  1'b0);
        step("sub",  5'b00001, E_SUB,  1'b0);
        step("ldr",  5'b00100, E_LDR,  1'b0);
        step("mul",  5'b00010, E_MUL,  1'b0);
        step("addi", 5'b00011, E_ADDI, 1'b0);
        step("str",  5'b00101, E_STR,  1'b0);
        step("fadd", 5'b01000, E_FADD, 1'b0);
        step("fldr", 5'b01100, E_FLDR, 1'b0);
        step("vadd", 5'b10000, E_VADD, 1'b0);
        step("vstr", 5'b10101, E_VSTR, 1'b0);
        step("b",    5'b11101, E_B,    1'b0);
        step("beq",  5'b11100, E_BEQ,  1'b0);
        step("ill11111", 5'b11111, 19'(0), 1'b1);
        step("ill00110", 5'b00110, 19'(0), 1'b1);
        step("ill10111", 5'b10111, 19'(0), 1'b1);
        step("nop",  5'b11000, 19'(0), 1'b0);
        step("ill11001", 5'b11001, 19'(0), 1'b1);
        step("vldr", 5'b10100, AS | MR | M2R | RW | VEC | RS1 | AD, 1'b0);
        // Reset mid-stream wins over a legal in-flight opcode
        Opcode = 5'b10000;
        rst    = 1'b0;
        @(posedge clk);
        #1;
        check_bundle("midrst", 19'(0), 1'b0);
        rst = 1'b1;
        prev_exp = 19'(0);
        prev_ill = 1'b0;
        step("postrst", 5'b00000, E_ADD, 1'b0);
        step("fsub", 5'b01001, A_SUB | RD | RW | PF, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
